// File: rtl/spatz_pkg.sv
// Shared Spatz VRF types: word address {vreg index, word offset} and data word.
package spatz_pkg;

  localparam int unsigned NRVREG = 32;
  localparam int unsigned VREG_W = $clog2(NRVREG);
  localparam int unsigned WORDS_PER_VREG = 4;
  localparam int unsigned WORD_W = $clog2(WORDS_PER_VREG);
  localparam int unsigned DATA_W = 32;

  typedef logic [VREG_W+WORD_W-1:0] vreg_addr_t;
  typedef logic [DATA_W-1:0] vreg_data_t;

  // Flat increment: offset carry bumps the vreg index and v31 wraps to v0.
  function automatic vreg_addr_t next_addr(input vreg_addr_t a);
    return a + vreg_addr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Registered FIFO without fall-through; memory is cleared on reset so the
// read port shows zero while empty after reset.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LAST = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0] FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rptr_q;
  logic [ADDR_DEPTH-1:0] wptr_q;
  logic [ADDR_DEPTH:0] cnt_q;
  logic do_push;
  logic do_pop;

  assign full_o = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop)
        rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spatz_vrf_operand_requester.sv
// Walks a run of VRF word addresses for one read port and buffers granted
// data, tagging the final word, for the functional unit to drain.
module spatz_vrf_operand_requester
  import spatz_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  vreg_addr_t           cmd_addr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  output vreg_addr_t           raddr_o,
  output logic                 re_o,
  input  vreg_data_t           rdata_i,
  input  logic                 rvalid_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output vreg_data_t           op_data_o,
  output logic                 op_last_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ = 1'b1;

  logic [0:0] state_q;
  vreg_addr_t addr_q;
  logic [LEN_WIDTH-1:0] rem_q;

  logic full;
  logic empty;
  logic [CNT_W-1:0] usage;
  logic [CNT_W:0] fill;
  logic grant;
  logic pop;
  logic [$bits(vreg_data_t):0] push_word;
  logic [$bits(vreg_data_t):0] head_word;

  // Gate on the registered fill level only, so op_ready_i never reaches re_o.
  assign fill = {full, usage};
  assign re_o = (state_q == REQ) && (fill < DEPTH_CNT);
  assign raddr_o = addr_q;
  assign cmd_ready_o = (state_q == IDLE);
  assign grant = re_o && rvalid_i;

  assign op_valid_o = !empty;
  assign pop = op_valid_o && op_ready_i;
  assign op_last_o = head_word[$bits(vreg_data_t)];
  assign op_data_o = head_word[$bits(vreg_data_t)-1:0];
  assign busy_o = (state_q == REQ) || op_valid_o;
  assign push_word = {rem_q == LEN_WIDTH'(1), rdata_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i && (cmd_len_i != '0)) begin
            addr_q <= cmd_addr_i;
            rem_q <= cmd_len_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (grant) begin
            addr_q <= next_addr(addr_q);
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_v3 #(
    .DATA_WIDTH($bits(vreg_data_t) + 1),
    .DEPTH     (FIFO_DEPTH)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .flush_i(1'b0),
    .full_o (full),
    .empty_o(empty),
    .usage_o(usage),
    .data_i (push_word),
    .push_i (grant),
    .data_o (head_word),
    .pop_i  (pop)
  );

endmodule

// File: doc/spatz_vrf_operand_requester.md
# spatz_vrf_operand_requester

Sequencer directly upstream of the vector register file on one read port. It accepts an operand-fetch command (start address plus word count) and walks the word addresses, holding each request until the VRF grants it. Granted read data is buffered in a small FIFO that the functional unit drains through a valid/ready handshake, with the final word tagged. One instance serves each VRF read port (vs2, vs1, vd, lsu, sld).

## Interface
- `FIFO_DEPTH`, 4: operand buffer depth in words; must be ≥ 2.
- `LEN_WIDTH`, 8: width of the word-count field.

- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `cmd_valid_i` input 1: command valid.
- `cmd_ready_o` output 1: command accepted when `cmd_valid_i && cmd_ready_o`.
- `cmd_addr_i` input `$bits(vreg_addr_t)`: first word address, formatted as {vreg index, word offset}.
- `cmd_len_i` input LEN_WIDTH: number of words to fetch; 0 means no-op.
- `raddr_o` output `$bits(vreg_addr_t)`: VRF read address.
- `re_o` output 1: VRF read enable.
- `rdata_i` input `$bits(vreg_data_t)`: VRF read data, valid in the same cycle as `rvalid_i`.
- `rvalid_i` input 1: VRF grant. The VRF may withhold it because of bank conflicts.
- `op_valid_o` output 1: operand word available.
- `op_ready_i` input 1: consumer pop.
- `op_data_o` output `$bits(vreg_data_t)`: operand word.
- `op_last_o` output 1: `op_data_o` is the last word of its command.
- `busy_o` output 1: a command is in progress or the FIFO is non-empty.

## Operation
- FSM has two states, IDLE and REQ.
- IDLE
  - `cmd_ready_o` = 1.
  - On handshake with `cmd_len_i` ≠ 0: latch `addr_q` = `cmd_addr_i`, `rem_q` = `cmd_len_i`, then go to REQ.
  - On handshake with `cmd_len_i` = 0: accept the command, produce nothing, stay in IDLE.
- REQ
  - `cmd_ready_o` = 0.
  - `re_o` = (FIFO count < FIFO_DEPTH). `raddr_o` = `addr_q`.
  - On `re_o && rvalid_i`:
    - push {`rem_q` == 1, `rdata_i`} into the FIFO;
    - `addr_q` += 1, modulo 2^`$bits(vreg_addr_t)`; the carry out of the word offset increments the vreg index, and v31 wraps to v0;
    - `rem_q` -= 1;
    - if `rem_q` was 1, go to IDLE.
- `rvalid_i` is ignored when `re_o` = 0. If `re_o` = 1 and `rvalid_i` = 0, `raddr_o` and `re_o` are held unchanged (stall).
- FIFO
  - The occupancy used for gating `re_o` is the current registered count. A pop in the same cycle does not free space for a push in that cycle.
  - Simultaneous push and pop is legal when the FIFO is non-full.
- `op_valid_o` = FIFO non-empty. A pop occurs on `op_valid_o && op_ready_i`.
- `busy_o` = (state == REQ) || `op_valid_o`.
- Reset, including mid-command:
  - FSM goes to IDLE; `addr_q` = 0 and `rem_q` = 0; the FIFO is emptied.
  - Outputs: `re_o` = 0, `op_valid_o` = 0, `op_last_o` = 0, `op_data_o` = 0, `raddr_o` = 0, `busy_o` = 0, `cmd_ready_o` = 1.
  - No partial command survives reset.

## Timing
- Command handshake in cycle N → first `re_o` in cycle N+1.
- Grant in cycle G → the word is visible on `op_data_o` in cycle G+1. The FIFO is registered, with no fall-through.
- Sustained throughput is one word per cycle when grants are continuous and `op_ready_i` is held high.
- Final grant in cycle G → IDLE in G+1; the next command can be accepted in G+1.
- All outputs are driven from registers or simple decodes of state/count. There is no combinational path from `op_ready_i` to `re_o`.

## Structure
- `vreg_addr_t`, `vreg_data_t` and `NRVREG` come from `spatz_pkg`. The FSM state enum is local.
- One sub-module: `fifo_v3` (common_cells), with DATA_WIDTH = `$bits(vreg_data_t)`+1 to carry the last tag and DEPTH = FIFO_DEPTH. Its `rst_ni` is driven by `~rst_i`, `flush_i` = 0, and `full_o`/`usage_o` feed the `re_o` gating.

## Test plan
Example configuration: 4 words per vreg, 2-bit word offset.
- **Basic fetch:** `cmd_addr` = {v3, w2}, len 4, `rvalid_i` tied 1, `op_ready_i` tied 1 → `raddr_o` sequence {v3,w2}, {v3,w3}, {v4,w0}, {v4,w1} on consecutive cycles; 4 pops with `op_last_o` set only on the 4th; `cmd_ready_o` high again the cycle after the 4th grant.
- **Conflict stall:** same command, `rvalid_i` low for 3 cycles on the second word → `raddr_o` holds {v3,w3} for 4 cycles; data order unchanged.
- **Backpressure:** `op_ready_i` = 0, len 6, FIFO_DEPTH 4 → exactly 4 grants, then `re_o` = 0. Raise `op_ready_i` → remaining 2 words fetched; 6 words total, last tag on the 6th.
- **Wrap and no-op:** `cmd_addr` = {v31,w3}, len 2 → second address is {v0,w0}. A len-0 command is accepted in 1 cycle with no `re_o` and no `op_valid_o`.
- **Reset mid-command:** assert `rst_i` after 2 of 5 grants → next cycle `re_o` = 0, `op_valid_o` = 0, `busy_o` = 0, `cmd_ready_o` = 1; a new command after reset fetches from its own address.
